alu_muldiv: RTL and testbench

//   Multi-cycle multiply/divide unit beside the ALU, downstream of ALUCTRL.

---
 rtl/alu_muldiv.sv | 125 ++++++++++++
 tb/tb_alu_muldiv.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Multi-cycle unsigned multiply/divide unit feeding the HI/LO registers.
// One result bit per cycle; busy stalls the pipeline until done pulses.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       ALUctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [5:0]       OP_MUL = 6'h13;
  localparam logic [5:0]       OP_DIV = 6'h34;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH-1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   count;
  // acc: {running high half, multiplier} for MUL; low half is the quotient for DIV
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   rem;

  logic is_mul, is_div, div0, can_accept, accept, last;

  assign is_mul     = (ALUctrl == OP_MUL);
  assign is_div     = (ALUctrl == OP_DIV);
  assign div0       = is_div && (b == '0);
  assign can_accept = (state == IDLE) || (state == DONE);
  assign accept     = start && can_accept && (is_mul || is_div);
  assign last       = (count == LAST);

  // shift-add step: add multiplicand into the high half, shift right by one
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nx;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};

  // restoring step: WIDTH+1-bit partial remainder against the divisor
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem, div_q;
  assign div_sh  = {rem, acc[WIDTH-1]};
  assign div_ge  = (div_sh >= {1'b0, opnd});
  assign div_rem = div_ge ? WIDTH'(div_sh - {1'b0, opnd}) : div_sh[WIDTH-1:0];
  assign div_q   = {acc[WIDTH-2:0], div_ge};

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept)    state_nx = is_mul ? MUL : (div0 ? DONE : DIV);
        else           state_nx = IDLE;
      end
      MUL, DIV: if (last) state_nx = DONE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MUL) || (state == DIV);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      acc   <= '0;
      opnd  <= '0;
      rem   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (accept) begin
      count <= '0;
      rem   <= '0;
      if (is_mul) begin
        acc  <= {{WIDTH{1'b0}}, b};
        opnd <= a;
      end else begin
        acc  <= {{WIDTH{1'b0}}, a};
        opnd <= b;
        if (div0) begin
          hi <= a;
          lo <= '1;
        end
      end
    end else begin
      case (state)
        MUL: begin
          count <= count + CNT_W'(1);
          acc   <= mul_nx;
          if (last) begin
            hi <= mul_nx[2*WIDTH-1:WIDTH];
            lo <= mul_nx[WIDTH-1:0];
          end
        end
        DIV: begin
          count           <= count + CNT_W'(1);
          rem             <= div_rem;
          acc[WIDTH-1:0]  <= div_q;
          if (last) begin
            hi <= div_rem;
            lo <= div_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: expected HI/LO pushed at issue time,
// popped and compared when done pulses; latency and busy length checked too.
module tb_alu_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   ALUctrl = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_assert = 0;
  int n_fail   = 0;
  logic [2*W-1:0] sb[$];
  logic [W-1:0]   m_hi = '0, m_lo = '0;

  alu_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUctrl(ALUctrl),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // drive one request for a single edge; expected result queued if push set
  task automatic issue(input logic [5:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit push, input bit hold);
    logic [2*W-1:0] e;
    ALUctrl = op; a = x; b = y; start = 1'b1;
    if (op == 6'h13) e = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    else if (y == '0) e = {x, {W{1'b1}}};
    else e = {x % y, x / y};
    if (push) sb.push_back(e);
    step;
    if (!hold) start = 1'b0;
  endtask

  // entered in cycle 1 after the accept edge
  task automatic wait_done(input string tag, input int exp_cyc, input int exp_busy);
    int cyc = 1;
    int nb  = 0;
    logic [2*W-1:0] e;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy === 1'b1) nb++;
      if (cyc == 16) begin
        chk({tag, " hi_hold"}, hi, m_hi);
        chk({tag, " lo_hold"}, lo, m_lo);
      end
      step;
      cyc++;
    end
    chk({tag, " latency"}, W'(cyc), W'(exp_cyc));
    chk({tag, " busy_cycles"}, W'(nb), W'(exp_busy));
    chk({tag, " busy_at_done"}, W'(busy), W'(0));
    if (sb.size() == 0) begin
      chk({tag, " scoreboard_empty"}, W'(0), W'(1));
    end else begin
      e = sb.pop_front();
      chk({tag, " hi"}, hi, e[2*W-1:W]);
      chk({tag, " lo"}, lo, e[W-1:0]);
      m_hi = e[2*W-1:W];
      m_lo = e[W-1:0];
    end
  endtask

  task automatic after_done(input string tag);
    step;
    chk({tag, " done_drop"}, W'(done), W'(0));
    chk({tag, " idle_busy"}, W'(busy), W'(0));
    chk({tag, " hi_keep"}, hi, m_hi);
    chk({tag, " lo_keep"}, lo, m_lo);
  endtask

  initial begin
    logic [W-1:0] x, y;

    rst = 1'b0;
    step; step;
    chk("reset busy", W'(busy), W'(0));
    chk("reset done", W'(done), W'(0));
    chk("reset hi", hi, '0);
    chk("reset lo", lo, '0);
    rst = 1'b1;
    step;

    issue(6'h13, 32'd7, 32'd6, 1'b1, 1'b0);
    wait_done("mul7x6", 33, 32);
    after_done("mul7x6");

    issue(6'h13, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    wait_done("mulmax", 33, 32);
    after_done("mulmax");

    issue(6'h34, 32'd100, 32'd7, 1'b1, 1'b0);
    wait_done("div100_7", 33, 32);
    after_done("div100_7");

    issue(6'h34, 32'd5, 32'd0, 1'b1, 1'b0);
    wait_done("div5_0", 1, 0);
    after_done("div5_0");

    for (int i = 0; i < 3; i++) begin
      x = $urandom; y = $urandom;
      issue(6'h13, x, y, 1'b1, 1'b0);
      wait_done("mul_rand", 33, 32);
      x = $urandom; y = W'($urandom_range(1, 1000));
      issue(6'h34, x, y, 1'b1, 1'b0);
      wait_done("div_rand", 33, 32);
    end
    issue(6'h34, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    wait_done("div_eq", 33, 32);
    after_done("div_eq");

    // start held through busy: no restart; the held start in DONE begins op 2
    issue(6'h13, 32'd7, 32'd6, 1'b1, 1'b1);
    a = 32'd3; b = 32'd5;
    sb.push_back(64'd15);
    wait_done("hold_op1", 33, 32);
    step;
    chk("hold_op2 busy", W'(busy), W'(1));
    chk("hold_op2 done", W'(done), W'(0));
    start = 1'b0;
    wait_done("hold_op2", 33, 32);

    ALUctrl = 6'h02; a = 32'd9; b = 32'd9; start = 1'b1;
    step;
    chk("ignored busy", W'(busy), W'(0));
    chk("ignored done", W'(done), W'(0));
    step; step;
    chk("ignored busy_later", W'(busy), W'(0));
    chk("ignored hi", hi, m_hi);
    chk("ignored lo", lo, m_lo);
    start = 1'b0;
    step;

    issue(6'h13, 32'hFFFFFFFF, 32'd3, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step;
    chk("midop busy", W'(busy), W'(1));
    rst = 1'b0;
    step;
    chk("midrst busy", W'(busy), W'(0));
    chk("midrst done", W'(done), W'(0));
    chk("midrst hi", hi, '0);
    chk("midrst lo", lo, '0);
    rst = 1'b1;
    m_hi = '0; m_lo = '0;
    step;
    issue(6'h13, 32'd3, 32'd3, 1'b1, 1'b0);
    wait_done("mul3x3", 33, 32);
    after_done("mul3x3");

    chk("scoreboard drained", W'(sb.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
